// File: rtl/nfc_pkg.sv
// Shared constants and types for the NAND-to-NAND page copy engine.
// Holds the flash command opcodes, FSM state and error code encodings.
package nfc_pkg;

  localparam logic [7:0] CMD_READ = 8'h00;
  localparam logic [7:0] CMD_PROG = 8'h80;
  localparam logic [7:0] CMD_CONF = 8'h10;
  localparam logic [7:0] CMD_STAT = 8'h70;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A_CMD,
    ST_A_ADDR,
    ST_A_WAIT,
    ST_XFER,
    ST_B_CONF,
    ST_B_WAIT,
    ST_B_STAT,
    ST_NEXT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_TMO   = 2'd2,
    ERR_PROG  = 2'd3
  } err_e;

  // Address byte 0 is the column (always zero); bytes 1.. are the page, LSB first.
  function automatic logic [7:0] addr_byte(input logic [31:0] page, input logic [31:0] idx);
    logic [31:0] sh;
    if (idx == 32'd0) return 8'h00;
    sh = page >> ((idx - 32'd1) << 3);
    return sh[7:0];
  endfunction

endpackage

// File: rtl/nfc_rb_watch.sv
// Ready/busy watcher: synchronises a flash R/B# pin, waits for low-then-high
// while active, and flags a timeout once the wait has lasted TMO_CYC cycles.
module nfc_rb_watch #(
  parameter int unsigned TMO_CYC = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rb_i,
  input  logic active_i,
  output logic ready_o,
  output logic timeout_o
);

  localparam int unsigned CW = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  logic          rb_s1_q;
  logic          rb_s2_q;
  logic          seen_low_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          expired;

  assign expired   = (cnt_q == CW'(TMO_CYC));
  assign cnt_d     = expired ? cnt_q : cnt_q + 1'b1;
  assign ready_o   = active_i & seen_low_q & rb_s2_q;
  assign timeout_o = active_i & ~ready_o & expired;

  // Leaving the wait clears the tracker, so every wait starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_s1_q    <= 1'b1;
      rb_s2_q    <= 1'b1;
      seen_low_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rb_s1_q <= rb_i;
      rb_s2_q <= rb_s1_q;
      if (!active_i) begin
        seen_low_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (!rb_s2_q) seen_low_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/nfc_copy_engine.sv
// Copies a page range from flash A to the same pages of flash B, with optional
// program-status verify and ready/busy timeouts reported through err_code.
module nfc_copy_engine
  import nfc_pkg::*;
#(
  parameter int unsigned PAGE_BYTES = 512,
  parameter int unsigned PAGE_AW    = 9,
  parameter int unsigned VERIFY     = 1,
  parameter int unsigned TMO_CYC    = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PAGE_AW-1:0] first_page,
  input  logic [PAGE_AW-1:0] last_page,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [PAGE_AW-1:0] fail_page,
  inout  wire  [7:0]         F_IO_A,
  output logic               F_CLE_A,
  output logic               F_ALE_A,
  output logic               F_REN_A,
  output logic               F_WEN_A,
  input  logic               F_RB_A,
  inout  wire  [7:0]         F_IO_B,
  output logic               F_CLE_B,
  output logic               F_ALE_B,
  output logic               F_REN_B,
  output logic               F_WEN_B,
  input  logic               F_RB_B
);

  localparam int unsigned ROW_CYC    = (PAGE_AW + 7) / 8;
  localparam int unsigned ADDR_STEPS = 2 * (1 + ROW_CYC);
  localparam int unsigned BCW        = $clog2(PAGE_BYTES);

  state_e             state_q;
  logic [3:0]         step_q;
  logic [BCW-1:0]     byte_cnt_q;
  logic [PAGE_AW-1:0] page_q;
  logic [PAGE_AW-1:0] last_q;
  logic               busy_q, done_q, err_q;
  err_e               err_code_q;
  logic [PAGE_AW-1:0] fail_page_q;
  logic               cle_a_q, ale_a_q, wen_a_q, ren_a_q, oe_a_q;
  logic               cle_b_q, ale_b_q, wen_b_q, ren_b_q, oe_b_q;
  logic [7:0]         io_a_q;
  logic [7:0]         io_b_q;
  logic [7:0]         next_addr;

  logic [1:0] rb_pin, rb_active, rb_ready, rb_tmo;

  assign rb_pin    = {F_RB_B, F_RB_A};
  assign rb_active = {state_q == ST_B_WAIT, state_q == ST_A_WAIT};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rb
      nfc_rb_watch #(.TMO_CYC(TMO_CYC)) u_rb (
        .clk       (clk),
        .rst_n     (rst),
        .rb_i      (rb_pin[gi]),
        .active_i  (rb_active[gi]),
        .ready_o   (rb_ready[gi]),
        .timeout_o (rb_tmo[gi])
      );
    end
  endgenerate

  assign next_addr = addr_byte(32'(page_q), (32'(step_q) + 32'd1) >> 1);

  assign F_IO_A    = oe_a_q ? io_a_q : 8'hzz;
  assign F_IO_B    = oe_b_q ? io_b_q : 8'hzz;
  assign F_CLE_A   = cle_a_q;
  assign F_ALE_A   = ale_a_q;
  assign F_WEN_A   = wen_a_q;
  assign F_REN_A   = ren_a_q;
  assign F_CLE_B   = cle_b_q;
  assign F_ALE_B   = ale_b_q;
  assign F_WEN_B   = wen_b_q;
  assign F_REN_B   = ren_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign fail_page = fail_page_q;

  // Pins are registered; each cycle they fall back to idle unless a branch drives them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      byte_cnt_q  <= '0;
      page_q      <= '0;
      last_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      fail_page_q <= '0;
      cle_a_q     <= 1'b0;
      ale_a_q     <= 1'b0;
      wen_a_q     <= 1'b1;
      ren_a_q     <= 1'b1;
      oe_a_q      <= 1'b0;
      io_a_q      <= '0;
      cle_b_q     <= 1'b0;
      ale_b_q     <= 1'b0;
      wen_b_q     <= 1'b1;
      ren_b_q     <= 1'b1;
      oe_b_q      <= 1'b0;
      io_b_q      <= '0;
    end else begin
      cle_a_q <= 1'b0;
      ale_a_q <= 1'b0;
      wen_a_q <= 1'b1;
      ren_a_q <= 1'b1;
      oe_a_q  <= 1'b0;
      cle_b_q <= 1'b0;
      ale_b_q <= 1'b0;
      wen_b_q <= 1'b1;
      ren_b_q <= 1'b1;
      oe_b_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            fail_page_q <= '0;
            if (first_page > last_page) begin
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              err_code_q <= ERR_RANGE;
            end else begin
              busy_q  <= 1'b1;
              page_q  <= first_page;
              last_q  <= last_page;
              state_q <= ST_A_CMD;
              step_q  <= '0;
              cle_a_q <= 1'b1;
              wen_a_q <= 1'b0;
              oe_a_q  <= 1'b1;
              io_a_q  <= CMD_READ;
              cle_b_q <= 1'b1;
              wen_b_q <= 1'b0;
              oe_b_q  <= 1'b1;
              io_b_q  <= CMD_PROG;
            end
          end
        end

        ST_A_CMD: begin
          oe_a_q <= 1'b1;
          oe_b_q <= 1'b1;
          if (step_q == 4'd0) begin
            cle_a_q <= 1'b1;
            cle_b_q <= 1'b1;
            step_q  <= 4'd1;
          end else begin
            ale_a_q <= 1'b1;
            ale_b_q <= 1'b1;
            wen_a_q <= 1'b0;
            wen_b_q <= 1'b0;
            io_a_q  <= 8'h00;
            io_b_q  <= 8'h00;
            state_q <= ST_A_ADDR;
            step_q  <= '0;
          end
        end

        ST_A_ADDR: begin
          if (!step_q[0]) begin
            ale_a_q <= 1'b1;
            ale_b_q <= 1'b1;
            oe_a_q  <= 1'b1;
            oe_b_q  <= 1'b1;
            step_q  <= step_q + 4'd1;
          end else if (step_q == 4'(ADDR_STEPS - 1)) begin
            state_q <= ST_A_WAIT;
            step_q  <= '0;
          end else begin
            ale_a_q <= 1'b1;
            ale_b_q <= 1'b1;
            oe_a_q  <= 1'b1;
            oe_b_q  <= 1'b1;
            wen_a_q <= 1'b0;
            wen_b_q <= 1'b0;
            io_a_q  <= next_addr;
            io_b_q  <= next_addr;
            step_q  <= step_q + 4'd1;
          end
        end

        ST_A_WAIT: begin
          if (rb_ready[0]) begin
            state_q    <= ST_XFER;
            step_q     <= '0;
            byte_cnt_q <= '0;
            ren_a_q    <= 1'b0;
          end else if (rb_tmo[0]) begin
            if (!err_q) begin
              err_code_q  <= ERR_TMO;
              fail_page_q <= page_q;
            end
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        // c0: REN_A low; c1: byte captured and written to B; c2: WEN_B high.
        ST_XFER: begin
          if (step_q == 4'd0) begin
            io_b_q  <= F_IO_A;
            wen_b_q <= 1'b0;
            oe_b_q  <= 1'b1;
            step_q  <= 4'd1;
          end else if (step_q == 4'd1) begin
            oe_b_q <= 1'b1;
            step_q <= 4'd2;
          end else if (byte_cnt_q == BCW'(PAGE_BYTES - 1)) begin
            state_q <= ST_B_CONF;
            step_q  <= '0;
            cle_b_q <= 1'b1;
            wen_b_q <= 1'b0;
            oe_b_q  <= 1'b1;
            io_b_q  <= CMD_CONF;
          end else begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
            step_q     <= '0;
            ren_a_q    <= 1'b0;
          end
        end

        ST_B_CONF: begin
          if (step_q == 4'd0) begin
            cle_b_q <= 1'b1;
            oe_b_q  <= 1'b1;
            step_q  <= 4'd1;
          end else begin
            state_q <= ST_B_WAIT;
            step_q  <= '0;
          end
        end

        ST_B_WAIT: begin
          if (rb_ready[1]) begin
            if (VERIFY != 0) begin
              state_q <= ST_B_STAT;
              step_q  <= '0;
              cle_b_q <= 1'b1;
              wen_b_q <= 1'b0;
              oe_b_q  <= 1'b1;
              io_b_q  <= CMD_STAT;
            end else begin
              state_q <= ST_NEXT;
            end
          end else if (rb_tmo[1]) begin
            if (!err_q) begin
              err_code_q  <= ERR_TMO;
              fail_page_q <= page_q;
            end
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_B_STAT: begin
          if (step_q == 4'd0) begin
            cle_b_q <= 1'b1;
            oe_b_q  <= 1'b1;
            step_q  <= 4'd1;
          end else if (step_q == 4'd1) begin
            ren_b_q <= 1'b0;
            step_q  <= 4'd2;
          end else begin
            if (F_IO_B[0]) begin
              if (!err_q) begin
                err_code_q  <= ERR_PROG;
                fail_page_q <= page_q;
              end
              err_q <= 1'b1;
            end
            state_q <= ST_NEXT;
            step_q  <= '0;
          end
        end

        // Equality test before increment keeps the all-ones page from wrapping.
        ST_NEXT: begin
          if (page_q == last_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            page_q  <= page_q + 1'b1;
            state_q <= ST_A_CMD;
            step_q  <= '0;
            cle_a_q <= 1'b1;
            wen_a_q <= 1'b0;
            oe_a_q  <= 1'b1;
            io_a_q  <= CMD_READ;
            cle_b_q <= 1'b1;
            wen_b_q <= 1'b0;
            oe_b_q  <= 1'b1;
            io_b_q  <= CMD_PROG;
          end
        end

        ST_DONE: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nfc_copy_engine.sv
// Bench for nfc_copy_engine: behavioural flash A/B models log every latched
// bus byte, and each job's logs are compared to a stream built from the page range.
module tb_nfc_copy_engine;

  localparam int unsigned PB  = 4;
  localparam int unsigned AW  = 9;
  localparam int unsigned TMO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] first_page = '0;
  logic [AW-1:0] last_page = '0;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic [AW-1:0] fail_page;
  wire  [7:0]    F_IO_A, F_IO_B;
  logic          F_CLE_A, F_ALE_A, F_REN_A, F_WEN_A, F_RB_A;
  logic          F_CLE_B, F_ALE_B, F_REN_B, F_WEN_B, F_RB_B;

  nfc_copy_engine #(.PAGE_BYTES(PB), .PAGE_AW(AW), .VERIFY(1), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .first_page(first_page), .last_page(last_page),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .fail_page(fail_page),
    .F_IO_A(F_IO_A), .F_CLE_A(F_CLE_A), .F_ALE_A(F_ALE_A), .F_REN_A(F_REN_A),
    .F_WEN_A(F_WEN_A), .F_RB_A(F_RB_A),
    .F_IO_B(F_IO_B), .F_CLE_B(F_CLE_B), .F_ALE_B(F_ALE_B), .F_REN_B(F_REN_B),
    .F_WEN_B(F_WEN_B), .F_RB_B(F_RB_B)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model knobs, written only by the main initial block.
  int            busy_a_len = 10;
  int            busy_b_len = 10;
  bit            stuck_a = 1'b0;
  bit            stuck_b = 1'b0;
  bit            bad_en = 1'b0;
  logic [AW-1:0] bad_page = '0;
  bit            log_clr = 1'b0;
  logic [7:0]    mem_a [0:(1<<AW)-1][0:PB-1];

  // Flash model state.
  logic [9:0]    log_a[$];
  logic [9:0]    log_b[$];
  int            a_tcnt, b_tcnt, a_aidx, b_aidx, a_ptr, wfall_a, wfall_b, conf_cyc;
  logic [AW-1:0] a_page = '0;
  logic [AW-1:0] b_page = '0;
  logic          a_wen_p, a_ren_p, b_wen_p;
  logic [7:0]    b_stat;

  assign b_stat = (bad_en && b_page == bad_page) ? 8'hE1 : 8'hE0;
  assign F_IO_A = (!F_REN_A) ? mem_a[a_page][a_ptr % PB] : 8'hzz;
  assign F_IO_B = (!F_REN_B) ? b_stat : 8'hzz;

  always @(negedge clk) begin : flash_a
    if (log_clr) begin
      log_a.delete();
      wfall_a = 0;
    end
    if (!rst) begin
      a_tcnt = 0; a_aidx = 0; a_ptr = 0; a_wen_p = 1'b1; a_ren_p = 1'b1; F_RB_A = 1'b1;
    end else begin
      if (a_wen_p && !F_WEN_A) wfall_a++;
      if (!a_wen_p && F_WEN_A) begin
        log_a.push_back({F_CLE_A, F_ALE_A, F_IO_A});
        if (F_CLE_A) a_aidx = 0;
        else if (F_ALE_A) begin
          if (a_aidx == 1) a_page[7:0] = F_IO_A;
          if (a_aidx == 2) a_page[8] = F_IO_A[0];
          a_aidx++;
          if (a_aidx == 3) begin
            a_ptr = 0;
            if (!stuck_a) a_tcnt = busy_a_len + 2;
          end
        end
      end
      if (!a_ren_p && F_REN_A) a_ptr++;
      a_wen_p = F_WEN_A;
      a_ren_p = F_REN_A;
      if (a_tcnt > 0) a_tcnt--;
      F_RB_A = !(a_tcnt > 0 && a_tcnt <= busy_a_len);
    end
  end

  always @(negedge clk) begin : flash_b
    if (log_clr) begin
      log_b.delete();
      wfall_b = 0;
    end
    if (!rst) begin
      b_tcnt = 0; b_aidx = 0; b_wen_p = 1'b1; F_RB_B = 1'b1;
    end else begin
      if (b_wen_p && !F_WEN_B) wfall_b++;
      if (!b_wen_p && F_WEN_B) begin
        log_b.push_back({F_CLE_B, F_ALE_B, F_IO_B});
        if (F_CLE_B) begin
          b_aidx = 0;
          if (F_IO_B == 8'h10) begin
            conf_cyc = cyc;
            if (!stuck_b) b_tcnt = busy_b_len + 2;
          end
        end else if (F_ALE_B) begin
          if (b_aidx == 1) b_page[7:0] = F_IO_B;
          if (b_aidx == 2) b_page[8] = F_IO_B[0];
          b_aidx++;
        end
      end
      b_wen_p = F_WEN_B;
      if (b_tcnt > 0) b_tcnt--;
      F_RB_B = !(b_tcnt > 0 && b_tcnt <= busy_b_len);
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input int fp, input int lp);
    log_clr = 1'b1;
    tick();
    log_clr = 1'b0;
    first_page = AW'(fp);
    last_page  = AW'(lp);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_pins_idle(input string tag);
    check_eq({tag, "_cle_a"}, F_CLE_A, 0);
    check_eq({tag, "_ale_a"}, F_ALE_A, 0);
    check_eq({tag, "_wen_a"}, F_WEN_A, 1);
    check_eq({tag, "_ren_a"}, F_REN_A, 1);
    check_eq({tag, "_cle_b"}, F_CLE_B, 0);
    check_eq({tag, "_ale_b"}, F_ALE_B, 0);
    check_eq({tag, "_wen_b"}, F_WEN_B, 1);
    check_eq({tag, "_ren_b"}, F_REN_B, 1);
  endtask

  task automatic run_job(input int fp, input int lp, input int ba, input int bb,
                         input bit sa, input bit sb, input bit be, input int bp);
    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];
    int exp_code, exp_fail, n, done_cyc;
    busy_a_len = ba; busy_b_len = bb; stuck_a = sa; stuck_b = sb;
    bad_en = be; bad_page = AW'(bp);
    pulse_start(fp, lp);
    check_eq("start_wen_a", F_WEN_A, 0);
    check_eq("start_busy", busy, 1);
    check_eq("start_done", done, 0);
    for (n = 0; n < 6000 && !done; n++) tick();
    done_cyc = cyc;
    check_eq("job_done", done, 1);

    exp_code = 0;
    exp_fail = 0;
    for (int p = fp; p <= lp; p++) begin
      exp_a.push_back({2'b10, 8'h00});
      exp_a.push_back({2'b01, 8'h00});
      exp_a.push_back({2'b01, 8'(p)});
      exp_a.push_back({2'b01, 8'(p >> 8)});
      exp_b.push_back({2'b10, 8'h80});
      exp_b.push_back({2'b01, 8'h00});
      exp_b.push_back({2'b01, 8'(p)});
      exp_b.push_back({2'b01, 8'(p >> 8)});
      if (sa) begin
        exp_code = 2; exp_fail = p;
        break;
      end
      for (int b = 0; b < PB; b++) exp_b.push_back({2'b00, mem_a[p][b]});
      exp_b.push_back({2'b10, 8'h10});
      if (sb) begin
        exp_code = 2; exp_fail = p;
        break;
      end
      exp_b.push_back({2'b10, 8'h70});
      if (be && p == bp && exp_code == 0) begin
        exp_code = 3; exp_fail = p;
      end
    end

    check_eq("a_len", log_a.size(), exp_a.size());
    for (int i = 0; i < log_a.size() && i < exp_a.size(); i++)
      check_eq($sformatf("a_bus[%0d]", i), log_a[i], exp_a[i]);
    check_eq("b_len", log_b.size(), exp_b.size());
    for (int i = 0; i < log_b.size() && i < exp_b.size(); i++)
      check_eq($sformatf("b_bus[%0d]", i), log_b[i], exp_b[i]);
    check_eq("err", err, (exp_code != 0) ? 1 : 0);
    check_eq("err_code", err_code, exp_code);
    check_eq("fail_page", fail_page, exp_fail);
    check_eq("end_busy", busy, 0);
    if (sb) check_eq("tmo_latency_le_110", (done_cyc - conf_cyc) <= 110 ? 1 : 0, 1);
    $display("[TB] job %0d..%0d busyA=%0d busyB=%0d stuckA=%0d stuckB=%0d bad=%0d@%0d -> err_code=%0d fail_page=%0d",
             fp, lp, ba, bb, sa, sb, be, bp, err_code, fail_page);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, fp, lp;
    for (int p = 0; p < (1 << AW); p++)
      for (int b = 0; b < PB; b++) mem_a[p][b] = 8'($urandom);
    mem_a[3][0] = 8'h11; mem_a[3][1] = 8'h22; mem_a[3][2] = 8'h33; mem_a[3][3] = 8'h44;

    repeat (3) tick();
    check_pins_idle("reset");
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_err", err, 0);
    check_eq("reset_err_code", err_code, 0);
    check_eq("reset_fail_page", fail_page, 0);
    rst = 1'b1;
    repeat (2) tick();

    // Reversed range: error on the very next cycle, no flash activity.
    pulse_start(7, 2);
    check_eq("range_done", done, 1);
    check_eq("range_err", err, 1);
    check_eq("range_code", err_code, 1);
    repeat (5) tick();
    check_eq("range_no_wen", wfall_a + wfall_b, 0);
    $display("[TB] job 7..2 -> err_code=%0d", err_code);

    run_job(3, 3, 20, 20, 0, 0, 0, 0);
    run_job(0, 2, 50, 50, 0, 0, 0, 0);
    run_job(9'h1FE, 9'h1FF, 15, 25, 0, 0, 0, 0);
    run_job(4, 6, 10, 10, 0, 0, 1, 5);
    run_job(8, 9, 10, 10, 0, 1, 0, 0);
    run_job(12, 13, 10, 10, 1, 0, 0, 0);

    // Reset while copying data, then a clean job must still work.
    busy_a_len = 10; busy_b_len = 10; stuck_a = 1'b0; stuck_b = 1'b0; bad_en = 1'b0;
    pulse_start(10, 10);
    for (n = 0; n < 2000 && F_REN_A; n++) tick();
    check_eq("xfer_reached", F_REN_A, 0);
    rst = 1'b0;
    #1;
    check_pins_idle("midreset");
    check_eq("midreset_busy", busy, 0);
    check_eq("midreset_done", done, 0);
    tick();
    rst = 1'b1;
    tick();
    $display("[TB] reset asserted mid-transfer");
    run_job(10, 11, 12, 12, 0, 0, 0, 0);

    for (int j = 0; j < 5; j++) begin
      fp = int'($urandom_range(0, 508));
      lp = fp + int'($urandom_range(0, 2));
      run_job(fp, lp, int'($urandom_range(1, 60)), int'($urandom_range(1, 60)), 0, 0,
              bit'($urandom_range(0, 1)), fp + int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
